// File: rtl/bcrypt_pkg.sv
// bcrypt_pkg: constants and types shared by the Blowfish engines and key
// expansion. Holds the SRAM map (P-array and S-box placement), the table
// sizes and the encipher FSM state encoding.
package bcrypt_pkg;

  // Default SRAM word-address map
  localparam int P_ARRAY_OFFSET_DEFAULT = 4000;
  localparam int S_BOX_OFFSET_DEFAULT   = 0;

  // S-box sub-offsets from S_BOX_OFFSET
  localparam int S0_OFF = 0;
  localparam int S1_OFF = 256;
  localparam int S2_OFF = 512;
  localparam int S3_OFF = 768;

  localparam int P_ENTRIES = 18;
  localparam int ROUNDS    = 16;

  typedef enum logic [2:0] {
    IDLE,
    RND_P,
    RND_S01,
    RND_S23,
    FIN,
    DONE
  } bf_state_e;

endpackage

// File: rtl/blowfish_f.sv
// blowfish_f: combinational Blowfish round function.
//   s0_i..s3_i : S-box outputs S0[a], S1[b], S2[c], S3[d]
//   f_o        : ((s0 + s1) ^ s2) + s3, adds modulo 2^32
module blowfish_f (
  input  logic [31:0] s0_i,
  input  logic [31:0] s1_i,
  input  logic [31:0] s2_i,
  input  logic [31:0] s3_i,
  output logic [31:0] f_o
);

  assign f_o = ((s0_i + s1_i) ^ s2_i) + s3_i;

endmodule

// File: rtl/blowfish_encipher.sv
// blowfish_encipher: 16-round Blowfish encipher reading P-array and S-boxes
// from two asynchronous-read SRAMs. Read-only: write enables are held high
// and the data buses are never driven.
//   clk, reset          : clock, synchronous active-low reset
//   start, datal, datar : one-cycle request (IDLE only) and plaintext halves
//   addr/cs/we/oe_a/b   : SRAM A/B read port (controls active-low)
//   data_a, data_b      : SRAM data buses, only sampled
//   resultl, resultr    : registered ciphertext, held until the next FIN
//   done                : one-cycle pulse when the result is fresh
// Each round takes 3 cycles: P xor, S0/S1 fetch, S2/S3 fetch + swap.
module blowfish_encipher
  import bcrypt_pkg::*;
#(
  parameter int P_ARRAY_OFFSET = P_ARRAY_OFFSET_DEFAULT,
  parameter int S_BOX_OFFSET   = S_BOX_OFFSET_DEFAULT
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [31:0] datal,
  input  logic [31:0] datar,
  output logic [11:0] addr_a,
  inout  wire  [31:0] data_a,
  output logic        cs_a_l,
  output logic        we_a_l,
  output logic        oe_a_l,
  output logic [11:0] addr_b,
  inout  wire  [31:0] data_b,
  output logic        cs_b_l,
  output logic        we_b_l,
  output logic        oe_b_l,
  output logic [31:0] resultl,
  output logic [31:0] resultr,
  output logic        done
);

  localparam logic [11:0] P_BASE  = 12'(P_ARRAY_OFFSET);
  localparam logic [11:0] S0_BASE = 12'(S_BOX_OFFSET + S0_OFF);
  localparam logic [11:0] S1_BASE = 12'(S_BOX_OFFSET + S1_OFF);
  localparam logic [11:0] S2_BASE = 12'(S_BOX_OFFSET + S2_OFF);
  localparam logic [11:0] S3_BASE = 12'(S_BOX_OFFSET + S3_OFF);
  localparam logic [3:0]  LAST_RND = 4'(ROUNDS - 1);

  bf_state_e   state_q, state_d;
  logic [31:0] l_q, l_d, r_q, r_d;
  logic [31:0] s0_q, s0_d, s1_q, s1_d;
  logic [31:0] resl_q, resl_d, resr_q, resr_d;
  logic [3:0]  round_q, round_d;
  logic [31:0] f;

  blowfish_f u_f (
    .s0_i (s0_q),
    .s1_i (s1_q),
    .s2_i (data_a),
    .s3_i (data_b),
    .f_o  (f)
  );

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q <= IDLE;
      l_q     <= '0;
      r_q     <= '0;
      s0_q    <= '0;
      s1_q    <= '0;
      resl_q  <= '0;
      resr_q  <= '0;
      round_q <= '0;
    end else begin
      state_q <= state_d;
      l_q     <= l_d;
      r_q     <= r_d;
      s0_q    <= s0_d;
      s1_q    <= s1_d;
      resl_q  <= resl_d;
      resr_q  <= resr_d;
      round_q <= round_d;
    end
  end

  always_comb begin
    state_d = state_q;
    l_d     = l_q;
    r_d     = r_q;
    s0_d    = s0_q;
    s1_d    = s1_q;
    resl_d  = resl_q;
    resr_d  = resr_q;
    round_d = round_q;
    addr_a  = '0;
    addr_b  = '0;
    cs_a_l  = 1'b1;
    cs_b_l  = 1'b1;
    done    = 1'b0;

    case (state_q)
      IDLE: begin
        if (start) begin
          l_d     = datal;
          r_d     = datar;
          round_d = '0;
          state_d = RND_P;
        end
      end
      RND_P: begin
        cs_a_l  = 1'b0;
        addr_a  = P_BASE + {8'd0, round_q};
        l_d     = l_q ^ data_a;
        state_d = RND_S01;
      end
      RND_S01: begin
        cs_a_l  = 1'b0;
        cs_b_l  = 1'b0;
        addr_a  = S0_BASE + {4'd0, l_q[31:24]};
        addr_b  = S1_BASE + {4'd0, l_q[23:16]};
        s0_d    = data_a;
        s1_d    = data_b;
        state_d = RND_S23;
      end
      RND_S23: begin
        cs_a_l = 1'b0;
        cs_b_l = 1'b0;
        addr_a = S2_BASE + {4'd0, l_q[15:8]};
        addr_b = S3_BASE + {4'd0, l_q[7:0]};
        l_d    = r_q ^ f;
        r_d    = l_q;
        if (round_q == LAST_RND) begin
          state_d = FIN;
        end else begin
          round_d = round_q + 4'd1;
          state_d = RND_P;
        end
      end
      FIN: begin
        cs_a_l  = 1'b0;
        cs_b_l  = 1'b0;
        addr_a  = P_BASE + 12'(P_ENTRIES - 2);
        addr_b  = P_BASE + 12'(P_ENTRIES - 1);
        // final swap is undone here: left takes R, right takes L
        resl_d  = r_q ^ data_b;
        resr_d  = l_q ^ data_a;
        state_d = DONE;
      end
      DONE: begin
        done    = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign oe_a_l  = 1'b0;
  assign oe_b_l  = 1'b0;
  assign we_a_l  = 1'b1;
  assign we_b_l  = 1'b1;
  assign resultl = resl_q;
  assign resultr = resr_q;

endmodule

// File: tb/tb_blowfish_encipher.sv
// tb_blowfish_encipher: directed and random checks of blowfish_encipher
// against a shared SRAM image and a reference Blowfish model.
module tb_blowfish_encipher;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        start = 1'b0;
  logic [31:0] datal = '0, datar = '0;
  logic [11:0] addr_a, addr_b;
  wire  [31:0] data_a, data_b;
  logic        cs_a_l, we_a_l, oe_a_l, cs_b_l, we_b_l, oe_b_l;
  logic [31:0] resultl, resultr;
  logic        done;

  logic [31:0] mem [0:4095];

  int n_chk = 0, n_err = 0, we_bad = 0;

  logic [11:0] tr_a [0:60];
  logic [11:0] tr_b [0:60];
  logic        tr_csa [0:60];
  logic        tr_csb [0:60];

  always #5 clk = ~clk;

  blowfish_encipher dut (
    .clk(clk), .reset(reset), .start(start), .datal(datal), .datar(datar),
    .addr_a(addr_a), .data_a(data_a), .cs_a_l(cs_a_l), .we_a_l(we_a_l), .oe_a_l(oe_a_l),
    .addr_b(addr_b), .data_b(data_b), .cs_b_l(cs_b_l), .we_b_l(we_b_l), .oe_b_l(oe_b_l),
    .resultl(resultl), .resultr(resultr), .done(done)
  );

  // Both SRAMs hold the same image; asynchronous read while selected
  assign data_a = (!cs_a_l && !oe_a_l) ? mem[addr_a] : 'z;
  assign data_b = (!cs_b_l && !oe_b_l) ? mem[addr_b] : 'z;

  always @(negedge clk) if (we_a_l !== 1'b1 || we_b_l !== 1'b1) we_bad++;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got %h exp %h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] fref(input logic [31:0] x);
    return ((mem[{4'd0, x[31:24]}] + mem[12'd256 + {4'd0, x[23:16]}])
            ^ mem[12'd512 + {4'd0, x[15:8]}]) + mem[12'd768 + {4'd0, x[7:0]}];
  endfunction

  function automatic logic [63:0] bf_ref(input logic [31:0] l, input logic [31:0] r);
    logic [31:0] xl, xr, t;
    xl = l; xr = r;
    for (int i = 0; i < 16; i++) begin
      xl = xl ^ mem[12'd4000 + 12'(i)];
      xr = xr ^ fref(xl);
      t = xl; xl = xr; xr = t;
    end
    t = xl; xl = xr; xr = t;
    xr = xr ^ mem[12'd4016];
    xl = xl ^ mem[12'd4017];
    return {xl, xr};
  endfunction

  task automatic clear_mem();
    for (int i = 0; i < 4096; i++) mem[i] = '0;
  endtask

  // Issues start in cycle 0 and observes cycles 1..60 on falling edges.
  // Extra start pulses are raised in cycles p1/p2 (0 = none).
  task automatic run_op(input logic [31:0] l, input logic [31:0] r,
                        input int p1, input int p2,
                        output int done_cyc, output int n_done);
    @(negedge clk);
    start = 1'b1; datal = l; datar = r;
    done_cyc = -1; n_done = 0;
    for (int c = 1; c <= 60; c++) begin
      @(negedge clk);
      tr_a[c] = addr_a; tr_b[c] = addr_b; tr_csa[c] = cs_a_l; tr_csb[c] = cs_b_l;
      if (done) begin
        n_done++;
        if (done_cyc < 0) done_cyc = c;
      end
      start = (c == p1 || c == p2);
    end
    start = 1'b0;
  endtask

  task automatic check_op(input string tag, input logic [31:0] l, input logic [31:0] r);
    int dc, nd;
    logic [63:0] e;
    e = bf_ref(l, r);
    run_op(l, r, 0, 0, dc, nd);
    chk({tag, "_lat"}, 32'(dc), 32'd50);
    chk({tag, "_l"}, resultl, e[63:32]);
    chk({tag, "_r"}, resultr, e[31:0]);
  endtask

  initial begin
    int dc, nd;
    logic [31:0] rl, rr;
    logic [63:0] e;
    clear_mem();

    // reset state
    repeat (2) @(negedge clk);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_resl", resultl, 32'd0);
    chk("rst_resr", resultr, 32'd0);
    chk("rst_csa", 32'(cs_a_l), 32'd1);
    chk("rst_csb", 32'(cs_b_l), 32'd1);
    chk("rst_addra", 32'(addr_a), 32'd0);
    reset = 1'b1;
    @(negedge clk);

    // zero tables: plaintext passes through; extra starts in cycles 10 and 50 ignored
    run_op(32'h01234567, 32'h89ABCDEF, 10, 50, dc, nd);
    chk("t1_lat", 32'(dc), 32'd50);
    chk("t1_ndone", 32'(nd), 32'd1);
    chk("t1_l", resultl, 32'h89ABCDEF);
    chk("t1_r", resultr, 32'h01234567);
    chk("t1_idle", 32'(tr_csa[55]), 32'd1);

    // address trace
    run_op(32'h01020304, 32'h0, 0, 0, dc, nd);
    chk("t3_c1_a", 32'(tr_a[1]), 32'd4000);
    chk("t3_c1_csa", 32'(tr_csa[1]), 32'd0);
    chk("t3_c1_csb", 32'(tr_csb[1]), 32'd1);
    chk("t3_c2_a", 32'(tr_a[2]), 32'd1);
    chk("t3_c2_b", 32'(tr_b[2]), 32'd258);
    chk("t3_c3_a", 32'(tr_a[3]), 32'd515);
    chk("t3_c3_b", 32'(tr_b[3]), 32'd772);
    chk("t3_c49_a", 32'(tr_a[49]), 32'd4016);
    chk("t3_c49_b", 32'(tr_b[49]), 32'd4017);
    chk("t3_c50_csa", 32'(tr_csa[50]), 32'd1);

    // P[0]=1 only
    mem[4000] = 32'h1;
    run_op(32'h0, 32'h0, 0, 0, dc, nd);
    chk("t2_lat", 32'(dc), 32'd50);
    chk("t2_l", resultl, 32'h0);
    chk("t2_r", resultr, 32'h1);
    mem[4000] = 32'h0;

    // modulo add in F: S0[0]+S1[0] wraps to 1
    mem[0] = 32'hFFFFFFFF; mem[256] = 32'h2;
    run_op(32'h0, 32'h0, 0, 0, dc, nd);
    chk("t4_c5_a", 32'(tr_a[5]), 32'd0);
    chk("t4_c5_b", 32'(tr_b[5]), 32'd256);
    chk("t4_c6_a", 32'(tr_a[6]), 32'd512);
    chk("t4_c6_b", 32'(tr_b[6]), 32'd769);
    e = bf_ref(32'h0, 32'h0);
    chk("t4_l", resultl, e[63:32]);
    chk("t4_r", resultr, e[31:0]);

    // reset in cycle 20 of an operation
    @(negedge clk);
    start = 1'b1; datal = 32'hDEADBEEF; datar = 32'h12345678;
    @(negedge clk);
    start = 1'b0;
    repeat (19) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    chk("t6_done", 32'(done), 32'd0);
    chk("t6_resl", resultl, 32'd0);
    chk("t6_resr", resultr, 32'd0);
    chk("t6_csa", 32'(cs_a_l), 32'd1);
    chk("t6_csb", 32'(cs_b_l), 32'd1);
    nd = 0;
    for (int c = 0; c < 60; c++) begin
      @(negedge clk);
      if (done) nd++;
    end
    chk("t6_nodone", 32'(nd), 32'd0);
    check_op("t6_new", 32'hDEADBEEF, 32'h12345678);

    // random tables and plaintexts
    for (int i = 0; i < 1024; i++) mem[i] = $urandom;
    for (int i = 4000; i < 4018; i++) mem[i] = $urandom;
    for (int n = 0; n < 500; n++) begin
      rl = $urandom; rr = $urandom;
      e = bf_ref(rl, rr);
      run_op(rl, rr, 0, 0, dc, nd);
      chk("t5_lat", 32'(dc), 32'd50);
      chk("t5_l", resultl, e[63:32]);
      chk("t5_r", resultr, e[31:0]);
    end

    chk("we_high", 32'(we_bad), 32'd0);
    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end

endmodule

// File: doc/blowfish_encipher.md
Name: blowfish_encipher

Overview:
- Reads the P-array and S-boxes that the key-expansion block writes into the two SRAMs, and runs one 16-round Blowfish encipher on a 64-bit block.
- It is the read-side consumer of the same dual-SRAM interface, and the feistel engine that key expansion starts and waits on.
- It only reads: it never asserts a write and never drives either data bus.

Parameters:
P_ARRAY_OFFSET, 4000, word address of P[0]; P[0..17] are contiguous.
S_BOX_OFFSET, 0, word address of S0[0]; S0, S1, S2 and S3 sit at +0, +256, +512 and +768.

Ports:
clk  input  1  clock
reset  input  1  synchronous, active-low reset
start  input  1  one-cycle request; accepted only in IDLE
datal  input  32  left half of plaintext, sampled when start is accepted
datar  input  32  right half of plaintext, sampled when start is accepted
addr_a  output  12  SRAM A word address
data_a  inout  32  SRAM A data; permanently high-Z
cs_a_l, we_a_l, oe_a_l  output  1 each  SRAM A controls, active-low
addr_b  output  12  SRAM B word address
data_b  inout  32  SRAM B data; permanently high-Z
cs_b_l, we_b_l, oe_b_l  output  1 each  SRAM B controls, active-low
resultl  output  32  ciphertext left half, registered
resultr  output  32  ciphertext right half, registered
done  output  1  one-cycle pulse; result valid from this cycle onward

Behaviour:
- Reset and clock: reset is synchronous, active-low; clock is clk.
- Reset values: state=IDLE, done=0, resultl=resultr=0, internal L/R=0, round=0.
- Reset is honoured mid-operation: the next cycle is IDLE and no done is issued.
- SRAM access: asynchronous single-cycle read.
  - In a read cycle the port drives cs_l=0, oe_l=0, we_l=1 and its address combinationally from state.
  - Data is captured at the closing posedge of that cycle.
- Idle port: cs_l=1, oe_l=0, we_l=1, addr=0.
- we_a_l and we_b_l are 1 in every cycle; data_a and data_b are never driven.
- States: IDLE, RND_P, RND_S01, RND_S23, FIN, DONE.
- IDLE:
  - On start, L<=datal, R<=datar, round<=0, go to RND_P.
  - start is ignored in every other state.
- RND_P:
  - Port A reads P_ARRAY_OFFSET+round; port B idle.
  - L<=L^P[round].
- RND_S01:
  - Port A reads S_BOX_OFFSET+L[31:24]; port B reads S_BOX_OFFSET+256+L[23:16].
  - Latch s0 and s1.
- RND_S23:
  - Port A reads S_BOX_OFFSET+512+L[15:8]; port B reads S_BOX_OFFSET+768+L[7:0].
  - Compute F=((s0+s1)^s2)+s3, with both additions 32-bit modulo 2^32 and carries discarded.
  - Update L<=R^F, R<=L (swap).
  - If round==15, go to FIN; otherwise round<=round+1 and go to RND_P.
- FIN:
  - Port A reads P_ARRAY_OFFSET+16; port B reads P_ARRAY_OFFSET+17, in the same cycle.
  - resultl<=R^P[17], resultr<=L^P[16] (undo the final swap).
- DONE: done=1 for exactly one cycle, then IDLE.
- Results hold until overwritten by the next FIN.
- Latency:
  - start is high in cycle 0.
  - Rounds occupy cycles 1..48 at 3 cycles per round.
  - FIN is cycle 49; done=1 in cycle 50.
  - The earliest next accepted start is cycle 51.
- Address width: P offsets add within 12 bits (4000+17 < 4096). S addresses are offset plus zero-extended byte.
- Start in the DONE cycle is ignored; start needs IDLE.

Decomposition:
- bcrypt_pkg holds:
  - constants P_ARRAY_OFFSET_DEFAULT=4000, S_BOX_OFFSET_DEFAULT=0;
  - S-box sub-offsets 0/256/512/768;
  - P_ENTRIES=18 and ROUNDS=16;
  - the state enum typedef.
- Key expansion shares these constants.
- One sub-module is natural: blowfish_f, combinational, computing F from s0..s3. It is reused by any later pipelined engine.

Test Plan:
1. All P=0 and all S=0, start with datal=0x01234567, datar=0x89ABCDEF -> done in cycle 50; resultl=0x89ABCDEF, resultr=0x01234567; we_a_l=we_b_l=1 throughout; data buses Z.
2. P[0]=0x00000001 and everything else 0, input (0,0) -> resultl=0x00000000, resultr=0x00000001.
3. Address trace with datal=0x01020304 and all tables 0:
   - cycle 1: addr_a=4000, cs_a_l=0, cs_b_l=1;
   - cycle 2: addr_a=1, addr_b=258;
   - cycle 3: addr_a=515, addr_b=772;
   - cycle 49: addr_a=4016, addr_b=4017.
4. Modulo-add check: S0[0]=0xFFFFFFFF, S1[0]=2, everything else 0, input (0,0):
   - round 0 F=1;
   - cycle 5: addr_a=0, addr_b=256;
   - cycle 6: addr_a=512, addr_b=769.
5. Random P/S contents and 500 random plaintexts vs the C Blowfish model -> bit-exact resultl/resultr. Also pulse start during cycles 10 and 50 -> ignored, one done per accepted start.
6. Deassert reset in cycle 20 of an operation -> next cycle IDLE, done=0, resultl=resultr=0, cs_a_l=cs_b_l=1. A new start then completes normally at +50.
